work_steal_scheduler: RTL and testbench

- Sequences the PU-to-PU crossbar's work-stealing path in the BFS accelerator.
- Monitors per-PU frontier-queue occupancy and picks an idle thief PU and the most-loaded victim PU.
- Drives steal_en, steal_from and steal_to for a bounded burst of transfers, then enforces a cooldown before the next decision.

---
 rtl/work_steal_scheduler.sv | 174 +++++++++++++++++
 tb/tb_work_steal_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/work_steal_scheduler.sv
// work_steal_scheduler: picks an idle thief PU and the most-loaded victim PU from the per-PU
// frontier occupancies. It then holds the crossbar steal path open for a bounded burst and waits
// out a cooldown before the next decision.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable_i          a BFS level is in progress
//   pu_occupancy_i    flattened occupancies, PU k at [k*OCC_BITS +: OCC_BITS]
//   xfer_fire_i       one pulse per stolen item accepted at the thief's crossbar output
//   steal_en_o        steal connection active
//   steal_from_o      victim index (held while steal_en_o is low)
//   steal_to_o        thief index (held while steal_en_o is low)
//   busy_o            scheduler is in SCAN, STEAL or COOL
//   steal_count_o     bursts that moved at least one item, saturating
module work_steal_scheduler #(
  parameter int unsigned NUM_PU      = 16,
  parameter int unsigned OCC_BITS    = 8,
  parameter int unsigned LOW_THRESH  = 0,
  parameter int unsigned HIGH_THRESH = 4,
  parameter int unsigned STEAL_BEATS = 4,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned COOLDOWN    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic [NUM_PU*OCC_BITS-1:0]  pu_occupancy_i,
  input  logic                        xfer_fire_i,
  output logic                        steal_en_o,
  output logic [$clog2(NUM_PU)-1:0]   steal_from_o,
  output logic [$clog2(NUM_PU)-1:0]   steal_to_o,
  output logic                        busy_o,
  output logic [15:0]                 steal_count_o
);

  localparam int unsigned IdxW = $clog2(NUM_PU);
  localparam int unsigned CntW = 16;

  localparam logic [OCC_BITS-1:0] LowTh    = OCC_BITS'(LOW_THRESH);
  localparam logic [OCC_BITS-1:0] HighTh   = OCC_BITS'(HIGH_THRESH);
  localparam logic [CntW-1:0]     BeatsMax = CntW'(STEAL_BEATS);
  localparam logic [CntW-1:0]     TmoMax   = CntW'(TIMEOUT);
  localparam logic [CntW-1:0]     CoolLast = CntW'(COOLDOWN - 1);

  typedef enum logic [1:0] {StIdle, StScan, StSteal, StCool} state_e;

  state_e            state_q;
  logic              steal_en_q, busy_q;
  logic [IdxW-1:0]   steal_from_q, steal_to_q, rr_ptr_q;
  logic [15:0]       steal_count_q;
  logic [CntW-1:0]   beats_q, tmo_q, cool_q;

  logic [OCC_BITS-1:0] occ [NUM_PU];
  logic                thief_found, pair_valid;
  logic [IdxW-1:0]     thief_idx, victim_idx;
  logic [OCC_BITS-1:0] victim_occ;
  logic [CntW-1:0]     beats_inc, tmo_inc;
  logic                beats_hit, tmo_hit, burst_done, burst_moved;

  always_comb begin
    for (int unsigned k = 0; k < NUM_PU; k++) begin
      occ[k] = pu_occupancy_i[k*OCC_BITS +: OCC_BITS];
    end
  end

  // Thief: first idle PU searching circularly from rr_ptr_q (index wraps by truncation).
  // Victim: strict '>' keeps the lowest index on ties.
  always_comb begin
    logic [IdxW-1:0] cand;
    cand        = '0;
    thief_found = 1'b0;
    thief_idx   = '0;
    for (int unsigned i = 0; i < NUM_PU; i++) begin
      cand = rr_ptr_q + IdxW'(i);
      if (!thief_found && (occ[cand] <= LowTh)) begin
        thief_found = 1'b1;
        thief_idx   = cand;
      end
    end
    victim_idx = '0;
    victim_occ = occ[0];
    for (int unsigned i = 1; i < NUM_PU; i++) begin
      if (occ[i] > victim_occ) begin
        victim_occ = occ[i];
        victim_idx = IdxW'(i);
      end
    end
    pair_valid = thief_found && (victim_occ >= HighTh) && (victim_idx != thief_idx);
  end

  // A transfer on the limit cycle clears the timeout, so it wins over the timeout.
  always_comb begin
    beats_inc   = beats_q + CntW'(1);
    tmo_inc     = tmo_q + CntW'(1);
    beats_hit   = xfer_fire_i && (beats_inc >= BeatsMax);
    tmo_hit     = !xfer_fire_i && (tmo_inc >= TmoMax);
    burst_done  = !enable_i || beats_hit || tmo_hit;
    burst_moved = xfer_fire_i || (beats_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      steal_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      steal_from_q  <= '0;
      steal_to_q    <= '0;
      rr_ptr_q      <= '0;
      steal_count_q <= '0;
      beats_q       <= '0;
      tmo_q         <= '0;
      cool_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_q <= StScan;
            busy_q  <= 1'b1;
          end
        end
        StScan: begin
          if (!enable_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (pair_valid) begin
            state_q      <= StSteal;
            steal_en_q   <= 1'b1;
            steal_from_q <= victim_idx;
            steal_to_q   <= thief_idx;
            beats_q      <= '0;
            tmo_q        <= '0;
          end
        end
        StSteal: begin
          if (burst_done) begin
            steal_en_q <= 1'b0;
            rr_ptr_q   <= steal_to_q + IdxW'(1);
            cool_q     <= '0;
            if (burst_moved && (steal_count_q != 16'hFFFF)) begin
              steal_count_q <= steal_count_q + 16'd1;
            end
            state_q <= (COOLDOWN == 0) ? StScan : StCool;
          end else if (xfer_fire_i) begin
            beats_q <= beats_inc;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        StCool: begin
          if (!enable_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cool_q == CoolLast) begin
            state_q <= StScan;
          end else begin
            cool_q <= cool_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign steal_en_o    = steal_en_q;
  assign steal_from_o  = steal_from_q;
  assign steal_to_o    = steal_to_q;
  assign busy_o        = busy_q;
  assign steal_count_o = steal_count_q;

endmodule

// File: tb/tb_work_steal_scheduler.sv
// Bench for work_steal_scheduler: directed scenarios followed by randomized bursts. Each one is
// checked against a reference built from the selection and burst-termination rules.
module tb_work_steal_scheduler;

  localparam int NP = 16;
  localparam int OB = 8;
  localparam int SB = 4;
  localparam int TO = 16;
  localparam int CD = 8;
  localparam int HT = 4;
  localparam int LT = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              xfer = 1'b0;
  logic [NP*OB-1:0]  pu_occ = '0;
  logic              steal_en, busy;
  logic [3:0]        steal_from, steal_to;
  logic [15:0]       steal_count;

  int occ [NP];
  int total = 0;
  int bad = 0;
  int exp_rr = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  work_steal_scheduler #(
    .NUM_PU(NP), .OCC_BITS(OB), .LOW_THRESH(LT), .HIGH_THRESH(HT),
    .STEAL_BEATS(SB), .TIMEOUT(TO), .COOLDOWN(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .pu_occupancy_i(pu_occ),
    .xfer_fire_i(xfer), .steal_en_o(steal_en), .steal_from_o(steal_from),
    .steal_to_o(steal_to), .busy_o(busy), .steal_count_o(steal_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic pack_occ();
    for (int k = 0; k < NP; k++) pu_occ[k*OB +: OB] = occ[k][OB-1:0];
  endtask

  function automatic int find_thief(input int rr);
    for (int k = 0; k < NP; k++) begin
      if (occ[(rr + k) % NP] <= LT) return (rr + k) % NP;
    end
    return -1;
  endfunction

  function automatic int find_victim();
    int best = 0;
    for (int k = 1; k < NP; k++) if (occ[k] > occ[best]) best = k;
    return best;
  endfunction

  // Burst length in cycles and items moved for a per-cycle xfer pattern.
  task automatic burst_model(input bit [127:0] pat, output int len, output int beats);
    int idle = 0;
    beats = 0;
    len = -1;
    for (int c = 1; c <= 120; c++) begin
      if (pat[c-1]) begin beats++; idle = 0; end
      else idle++;
      if (beats == SB || idle == TO) begin len = c; break; end
    end
  endtask

  task automatic measure_burst(input bit [127:0] pat, output int len);
    len = -1;
    for (int c = 1; c <= 100; c++) begin
      xfer = pat[c-1];
      step();
      if (!steal_en) begin len = c; break; end
    end
    xfer = 1'b0;
  endtask

  task automatic wait_en(output int gap);
    gap = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (steal_en) begin gap = c; break; end
    end
  endtask

  initial begin
    int gap, len, mlen, beats, t, v, tz, mode, any_en;
    bit [127:0] pat;

    for (int k = 0; k < NP; k++) occ[k] = 0;
    pack_occ();
    step();
    step();
    check("rst_en", steal_en, 0);
    check("rst_from", steal_from, 0);
    check("rst_to", steal_to, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", steal_count, 0);
    rst_n = 1'b1;
    step();

    // Single loaded PU: thief 0, victim 5, two cycles from enable to steal_en.
    occ[5] = 10;
    pack_occ();
    enable = 1'b1;
    step();
    check("scan_en", steal_en, 0);
    check("scan_busy", busy, 1);
    step();
    check("start_en", steal_en, 1);
    check("start_from", steal_from, 5);
    check("start_to", steal_to, 0);

    // Four back-to-back transfers end the burst on the fourth.
    xfer = 1'b1;
    step();
    step();
    step();
    check("held_b3", steal_en, 1);
    step();
    xfer = 1'b0;
    check("beats_end", steal_en, 0);
    exp_cnt = 1;
    exp_rr = 1;
    check("beats_cnt", steal_count, exp_cnt);

    wait_en(gap);
    check("cool_gap", gap, CD + 1);
    check("rr_to", steal_to, 1);
    check("rr_from", steal_from, 5);

    // No transfers: the burst times out, the count holds, the pointer still moves.
    measure_burst('0, mlen);
    check("tmo_len", mlen, TO);
    check("tmo_cnt", steal_count, exp_cnt);
    exp_rr = 2;

    // Nothing above the victim threshold: stuck in SCAN, stray xfer ignored.
    for (int k = 0; k < NP; k++) occ[k] = 3;
    pack_occ();
    any_en = 0;
    for (int c = 0; c < 30; c++) begin
      xfer = c[2];
      step();
      if (steal_en) any_en = 1;
    end
    xfer = 1'b0;
    check("low_no_en", any_en, 0);
    check("low_busy", busy, 1);
    check("low_cnt", steal_count, exp_cnt);

    // Tie between PU2 and PU7 resolves to 2; PU0 is the only thief.
    occ[0] = 0;
    occ[2] = 9;
    occ[7] = 9;
    pack_occ();
    step();
    check("tie_en", steal_en, 1);
    check("tie_from", steal_from, 2);
    check("tie_to", steal_to, 0);
    xfer = 1'b1;
    step();
    xfer = 1'b0;
    enable = 1'b0;
    step();
    check("dis_en", steal_en, 0);
    check("dis_busy_cool", busy, 1);
    step();
    check("dis_busy_idle", busy, 0);
    exp_cnt = 2;
    exp_rr = 1;
    check("dis_cnt", steal_count, exp_cnt);

    // Randomized occupancies and transfer patterns.
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < NP; k++) begin
        occ[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      end
      tz = int'($urandom_range(0, NP - 1));
      occ[tz] = 0;
      if (occ[find_victim()] < HT) occ[(tz + 1) % NP] = int'($urandom_range(HT, 255));
      pack_occ();
      t = find_thief(exp_rr);
      v = find_victim();
      if (it == 0) enable = 1'b1;
      wait_en(gap);
      check("rnd_gap", gap, (it == 0) ? 2 : CD + 1);
      check("rnd_from", steal_from, v);
      check("rnd_to", steal_to, t);
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 128; i++) begin
        case (mode)
          0: pat[i] = 1'b0;
          1: pat[i] = 1'($urandom_range(0, 1));
          2: pat[i] = ($urandom_range(0, 3) == 0);
          default: pat[i] = 1'b1;
        endcase
      end
      burst_model(pat, len, beats);
      measure_burst(pat, mlen);
      check("rnd_len", mlen, len);
      if (beats > 0) exp_cnt++;
      exp_rr = (t + 1) % NP;
      check("rnd_cnt", steal_count, exp_cnt);
    end

    // Reset in the middle of a burst clears outputs without a clock edge.
    for (int k = 0; k < NP; k++) occ[k] = 1;
    occ[6] = 0;
    occ[9] = 50;
    pack_occ();
    wait_en(gap);
    check("pre_rst_gap", gap, CD + 1);
    check("pre_rst_from", steal_from, 9);
    check("pre_rst_to", steal_to, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en", steal_en, 0);
    check("arst_from", steal_from, 0);
    check("arst_to", steal_to, 0);
    check("arst_cnt", steal_count, 0);
    check("arst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
